// File: rtl/sw_axi_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sw_axi_pkg
// Description : Shared constants and FSM state type for the sequence fetcher
//               (AXI read master feeding the Smith-Waterman PE loaders).
// Contents    : BEAT_BYTES, BASES_PER_BEAT, BASE_W, AXI width constants,
//               fetch_state_e.
// Revision    : 1.0 - initial release
// ============================================================================
package sw_axi_pkg;

  localparam int BEAT_BYTES     = 32;   // bytes per 256-bit AXI beat
  localparam int BASES_PER_BEAT = 128;  // 2-bit bases per beat
  localparam int BASE_W         = 2;    // bits per nucleotide
  localparam int AXI_ADDR_W     = 33;
  localparam int AXI_DATA_W     = 256;
  localparam int AXI_ID_W       = 8;
  localparam int AXI_LEN_W      = 8;    // AXI4 burst-length field width
  localparam int SEQ_LEN_W      = 16;   // beat-count request width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_e;

endpackage : sw_axi_pkg
`default_nettype wire

// File: rtl/axi_seq_fetch_if.sv
`default_nettype none
// ============================================================================
// Interface   : axi_seq_fetch_if
// Description : AXI AR + R channel bundle between the sequence fetcher
//               (master modport) and the DRAM read port (slave modport).
// Signals     : arready, arid, araddr, arlen, arvalid,
//               rid, rvalid, rdata, rready
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_seq_fetch_if
  import sw_axi_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int ID_W   = AXI_ID_W
) ();

  logic                 arready;
  logic [ID_W-1:0]      arid;
  logic [ADDR_W-1:0]    araddr;
  logic [AXI_LEN_W-1:0] arlen;
  logic                 arvalid;
  logic [ID_W-1:0]      rid;
  logic                 rvalid;
  logic [DATA_W-1:0]    rdata;
  logic                 rready;

  modport master (
    input  arready, rid, rvalid, rdata,
    output arid, araddr, arlen, arvalid, rready
  );

  modport slave (
    output arready, rid, rvalid, rdata,
    input  arid, araddr, arlen, arvalid, rready
  );

endinterface : axi_seq_fetch_if
`default_nettype wire

// File: rtl/seq_beat_fifo.sv
`default_nettype none
// ============================================================================
// Module      : seq_beat_fifo
// Description : Synchronous first-word-fall-through FIFO of AXI beats.
//               Status flags are registered; dout shows the head word
//               whenever empty=0.
// Ports       : clk, rst (async, active-high), push/din, pop/dout,
//               full, empty, count
// Revision    : 1.0 - initial release
// ============================================================================
module seq_beat_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4,                    // power of 2, >= 2
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // A push into a full FIFO is still accepted when a pop frees a slot in
  // the same cycle; a pop of an empty FIFO is meaningless and ignored.
  assign do_push = push & (~full_q | pop);
  assign do_pop  = pop & ~empty_q;
  assign count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
    end
  end

  // Storage carries no reset; validity is tracked by the flags.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule : seq_beat_fifo
`default_nettype wire

// File: rtl/axi_seq_fetch.sv
`default_nettype none
// ============================================================================
// Module      : axi_seq_fetch
// Description : AXI read master. Fetches num_beats_in single-beat bursts
//               from base_addr_in and streams the packed data out one 2-bit
//               base at a time, LSB first.
// Ports       : clk, rst (async, active-high)
//               start_in, base_addr_in, num_beats_in, busy_out, done_out
//               axi (axi_seq_fetch_if.master: AR + R channels)
//               base_out, base_valid_out, base_ready_in, err_out
// Config      : SEQ_FETCH_ID_CHECK_EN - enables in-order R-ID checking with
//               a sticky err_out; otherwise err_out is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_seq_fetch
  import sw_axi_pkg::*;
#(
  parameter int ADDR_W     = AXI_ADDR_W,
  parameter int DATA_W     = AXI_DATA_W,
  parameter int ID_W       = AXI_ID_W,
  parameter int LEN_W      = SEQ_LEN_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_in,
  input  logic [ADDR_W-1:0]  base_addr_in,
  input  logic [LEN_W-1:0]   num_beats_in,
  output logic               busy_out,
  output logic               done_out,
  axi_seq_fetch_if.master    axi,
  output logic [BASE_W-1:0]  base_out,
  output logic               base_valid_out,
  input  logic               base_ready_in,
  output logic               err_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 2;
  localparam int IDX_W = $clog2(BASES_PER_BEAT);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BASES_PER_BEAT - 1);

  fetch_state_e      state_q;
  logic              busy_q, done_q;
  logic              arvalid_q;
  logic [ADDR_W-1:0] araddr_q, addr_ptr_q;
  logic [ID_W-1:0]   arid_q;
  logic [LEN_W-1:0]  num_q, issued_q;
  logic [CNT_W-1:0]  outst_q;
  logic              rready_q;
  logic [IDX_W-1:0]  idx_q;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count, cnt_nxt;
  logic [DATA_W-1:0] fifo_head;

  logic              ar_hs, r_hs, r_expected, base_hs;
  logic              ar_slot_free, all_issued, ar_issue, drain_done;
  logic [OCC_W-1:0]  occupancy;

  assign ar_hs   = arvalid_q & axi.arready;
  assign r_hs    = axi.rvalid & rready_q;
  // The DRAM answers in the same cycle as the AR handshake, so that AR
  // already counts as outstanding for the beat arriving with it.
  assign r_expected = (outst_q != '0) | ar_hs;
  assign fifo_push  = r_hs & r_expected & (~fifo_full | fifo_pop);
  assign base_hs    = base_valid_out & base_ready_in;
  assign fifo_pop   = base_hs & (idx_q == IDX_LAST);
  assign cnt_nxt    = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

  // A held AR is counted as occupying a slot so that every issued request
  // is guaranteed room in the FIFO when its beat returns.
  assign occupancy    = OCC_W'(outst_q) + OCC_W'(fifo_count) + OCC_W'(arvalid_q);
  assign ar_slot_free = ~arvalid_q | axi.arready;
  assign all_issued   = (issued_q == num_q);
  assign ar_issue     = (state_q == ST_FETCH) & ~all_issued & ar_slot_free
                        & (occupancy < OCC_LIMIT);
  assign drain_done   = (outst_q == '0) &
                        (fifo_empty | ((fifo_count == CNT_W'(1)) & fifo_pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arid_q     <= '0;
      addr_ptr_q <= '0;
      num_q      <= '0;
      issued_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            num_q      <= num_beats_in;
            issued_q   <= '0;
            addr_ptr_q <= base_addr_in;
            busy_q     <= 1'b1;
            if (num_beats_in == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (ar_hs) arvalid_q <= 1'b0;
          if (ar_issue) begin
            arvalid_q  <= 1'b1;
            araddr_q   <= addr_ptr_q;
            arid_q     <= ID_W'(issued_q);
            addr_ptr_q <= addr_ptr_q + ADDR_W'(BEAT_BYTES);
            issued_q   <= issued_q + LEN_W'(1);
          end else if (all_issued && ar_slot_free) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outstanding-read tracking and registered R backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst_q  <= '0;
      rready_q <= 1'b0;
    end else begin
      rready_q <= (cnt_nxt != CNT_FULL);
      case ({ar_hs, fifo_push})
        2'b10:   outst_q <= outst_q + CNT_W'(1);
        2'b01:   outst_q <= outst_q - CNT_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  // Base index within the head word; wraps to 0 as the word is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (base_hs) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  seq_beat_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (axi.rdata),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef SEQ_FETCH_ID_CHECK_EN
  // Responses arrive in order, so the expected ID simply counts accepted
  // beats from the start of each fetch.
  logic [ID_W-1:0] exp_id_q;
  logic            err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_id_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start_in) begin
        exp_id_q <= '0;
      end else if (fifo_push) begin
        exp_id_q <= exp_id_q + ID_W'(1);
        if (axi.rid != exp_id_q) err_q <= 1'b1;
      end
    end
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

  assign axi.arvalid    = arvalid_q;
  assign axi.araddr     = araddr_q;
  assign axi.arid       = arid_q;
  assign axi.arlen      = '0;
  assign axi.rready     = rready_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign base_valid_out = ~fifo_empty;
  assign base_out       = fifo_empty ? '0 : fifo_head[{idx_q, 1'b0} +: BASE_W];

endmodule : axi_seq_fetch
`default_nettype wire

// File: tb/tb_axi_seq_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_seq_fetch
// Description : Scoreboard testbench for axi_seq_fetch with a zero-latency
//               DRAM model on the AR/R interface.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_seq_fetch;
  import sw_axi_pkg::*;

  localparam int ADDR_W = 33;
  localparam int DATA_W = 256;
  localparam int ID_W   = 8;
  localparam int LEN_W  = 16;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  num_beats;
  logic              busy, done, base_valid, base_ready, err;
  logic [1:0]        base;
  logic              arready_drv, stray_r, force_rid;

  axi_seq_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

  axi_seq_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_in       (start),
    .base_addr_in   (base_addr),
    .num_beats_in   (num_beats),
    .busy_out       (busy),
    .done_out       (done),
    .axi            (axi),
    .base_out       (base),
    .base_valid_out (base_valid),
    .base_ready_in  (base_ready),
    .err_out        (err)
  );

  // Beat contents as a function of address; address 0 yields ...ec471910.
  function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    for (int j = 0; j < 8; j++)
      w[32*j +: 32] = 32'hec471910 ^ (a[31:0] * 32'h9e3779b9) ^ (32'(j) * 32'h01000193);
    return w;
  endfunction

  // Zero-latency DRAM: R is presented in the same cycle as the AR handshake.
  always_comb begin
    axi.arready = arready_drv;
    axi.rvalid  = (axi.arvalid & arready_drv) | stray_r;
    axi.rdata   = beat_data(axi.araddr);
    axi.rid     = force_rid ? ID_W'(5) : axi.arid;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int ar_count = 0;
  int base_count = 0;
  int done_count = 0;
  logic [1:0] obs_first [4];

  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [ID_W-1:0]   exp_id_q   [$];
  logic [1:0]        exp_base_q [$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Monitor samples mid-cycle: handshakes seen here complete at the next posedge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (axi.arvalid && axi.arready) begin
        ar_count++;
        if (exp_addr_q.size() == 0) check_val("ar_unexpected", 64'(axi.araddr), 64'hFFFF_FFFF);
        else begin
          check_val("araddr", 64'(axi.araddr), 64'(exp_addr_q.pop_front()));
          check_val("arid", 64'(axi.arid), 64'(exp_id_q.pop_front()));
          check_val("arlen", 64'(axi.arlen), 64'd0);
        end
      end
      if (base_valid && base_ready) begin
        if (base_count < 4) obs_first[base_count] = base;
        base_count++;
        if (exp_base_q.size() == 0) check_val("base_unexpected", 64'(base), 64'hF);
        else check_val("base", 64'(base), 64'(exp_base_q.pop_front()));
      end
      if (done) done_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_sb();
    exp_addr_q.delete();
    exp_id_q.delete();
    exp_base_q.delete();
  endtask

  task automatic start_fetch(input logic [ADDR_W-1:0] addr, input int n, input bit expect_it);
    logic [DATA_W-1:0] w;
    logic [ADDR_W-1:0] a;
    if (expect_it) begin
      for (int k = 0; k < n; k++) begin
        a = addr + ADDR_W'(32 * k);
        exp_addr_q.push_back(a);
        exp_id_q.push_back(ID_W'(k));
        w = beat_data(a);
        for (int i = 0; i < BASES_PER_BEAT; i++) exp_base_q.push_back(w[2*i +: 2]);
      end
    end
    base_addr = addr;
    num_beats = LEN_W'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Waits for done_out, optionally randomising arready/base_ready meanwhile.
  task automatic wait_done(input string tag, input int budget, input bit rnd);
    int d0 = done_count;
    int i  = 0;
    while (done_count == d0 && i < budget) begin
      if (rnd) begin
        arready_drv = 1'($urandom_range(0, 1));
        base_ready  = ($urandom_range(0, 3) != 0);
      end
      tick();
      i++;
    end
    arready_drv = 1'b1;
    base_ready  = 1'b1;
    check_val({tag, "_done_seen"}, 64'(done_count != d0), 64'd1);
    check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
    check_val({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_sb_bases_left"}, 64'(exp_base_q.size()), 64'd0);
    check_val({tag, "_sb_ars_left"}, 64'(exp_addr_q.size()), 64'd0);
    if (done_count == d0) begin
      flush_sb();
      rst = 1'b1; tick(); rst = 1'b0; tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_done"}, 64'(done), 64'd0);
    check_val({tag, "_arvalid"}, 64'(axi.arvalid), 64'd0);
    check_val({tag, "_araddr"}, 64'(axi.araddr), 64'd0);
    check_val({tag, "_arid"}, 64'(axi.arid), 64'd0);
    check_val({tag, "_arlen"}, 64'(axi.arlen), 64'd0);
    check_val({tag, "_rready"}, 64'(axi.rready), 64'd0);
    check_val({tag, "_base_valid"}, 64'(base_valid), 64'd0);
    check_val({tag, "_base"}, 64'(base), 64'd0);
    check_val({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    int a0, b0, i;
    logic exp_err;
`ifdef SEQ_FETCH_ID_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b1; start = 1'b0; base_addr = '0; num_beats = '0;
    base_ready = 1'b1; arready_drv = 1'b1; stray_r = 1'b0; force_rid = 1'b0;

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_val("rready_after_reset", 64'(axi.rready), 64'd1);

    // One beat from 0x0
    base_count = 0;
    start_fetch('0, 1, 1'b1);
    check_val("t1_busy", 64'(busy), 64'd1);
    tick();
    check_val("t1_arvalid", 64'(axi.arvalid), 64'd1);
    check_val("t1_base_valid_early", 64'(base_valid), 64'd0);
    tick();
    check_val("t1_base_valid", 64'(base_valid), 64'd1);
    wait_done("t1", 400, 1'b0);
    check_val("t1_first_bases", 64'({obs_first[0], obs_first[1], obs_first[2], obs_first[3]}),
              64'({2'd0, 2'd0, 2'd1, 2'd0}));
    check_val("t1_base_count", 64'(base_count), 64'd128);

    // Eight beats, full throughput
    a0 = ar_count; b0 = base_count;
    start_fetch('0, 8, 1'b1);
    wait_done("t2", 3000, 1'b0);
    check_val("t2_ar_count", 64'(ar_count - a0), 64'd8);
    check_val("t2_base_count", 64'(base_count - b0), 64'd1024);
    check_val("t2_err", 64'(err), 64'd0);

    // Random AR/base backpressure
    b0 = base_count;
    start_fetch(ADDR_W'(33'h1_0000_1000), 5, 1'b1);
    wait_done("t3", 6000, 1'b1);
    check_val("t3_base_count", 64'(base_count - b0), 64'd640);

    // Downstream stalled: AR issue limited by FIFO depth; start while busy ignored
    base_ready = 1'b0;
    a0 = ar_count;
    start_fetch(ADDR_W'(33'h2000), 8, 1'b1);
    repeat (10) tick();
    start_fetch(ADDR_W'(33'h9000), 3, 1'b0);
    repeat (30) tick();
    check_val("t4_ar_limit", 64'((ar_count - a0) <= DEPTH), 64'd1);
    check_val("t4_ar_nonzero", 64'((ar_count - a0) > 0), 64'd1);
    check_val("t4_rready_full", 64'(axi.rready), 64'd0);
    check_val("t4_base_valid", 64'(base_valid), 64'd1);
    base_ready = 1'b1;
    wait_done("t4", 3000, 1'b0);
    check_val("t4_ar_total", 64'(ar_count - a0), 64'd8);

    // Zero-length request
    a0 = ar_count;
    start_fetch('0, 0, 1'b1);
    check_val("t5_busy", 64'(busy), 64'd1);
    check_val("t5_done", 64'(done), 64'd1);
    check_val("t5_arvalid", 64'(axi.arvalid), 64'd0);
    tick();
    check_val("t5_busy_after", 64'(busy), 64'd0);
    check_val("t5_done_after", 64'(done), 64'd0);
    check_val("t5_no_ar", 64'(ar_count - a0), 64'd0);

    // Reset mid-fetch, then a stray R beat, then a clean fetch
    a0 = ar_count;
    start_fetch(ADDR_W'(33'h4000), 8, 1'b1);
    i = 0;
    while ((ar_count - a0) < 3 && i < 100) begin tick(); i++; end
    check_val("t6_reached_beat3", 64'((ar_count - a0) >= 3), 64'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("t6_midreset");
    flush_sb();
    tick();
    rst = 1'b0;
    tick();
    stray_r = 1'b1;
    tick();
    stray_r = 1'b0;
    tick();
    check_val("t6_stray_dropped", 64'(base_valid), 64'd0);
    check_val("t6_idle", 64'(busy), 64'd0);
    b0 = base_count;
    start_fetch(ADDR_W'(33'h4000), 2, 1'b1);
    wait_done("t6", 1000, 1'b0);
    check_val("t6_base_count", 64'(base_count - b0), 64'd256);

    // Wrong R-ID on the first beat
    force_rid = 1'b1;
    start_fetch(ADDR_W'(33'h6000), 2, 1'b1);
    tick();
    tick();
    force_rid = 1'b0;
    wait_done("t7", 1000, 1'b0);
    check_val("t7_err", 64'(err), 64'(exp_err));
    repeat (3) tick();
    check_val("t7_err_sticky", 64'(err), 64'(exp_err));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_axi_seq_fetch
`default_nettype wire
